mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and writeback.
- Issues word loads and stores to the data memory over a valid/ready handshake.
- Stalls the pipeline while memory is busy, then latches the MEM/WB register.
- Drives the writeback value that is forwarded back to EX (wb_data).

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles before a memory access is aborted with a bus error.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_mem_alu_result  in  32  address for loads/stores, or the ALU/link result.
- ex_mem_store_val  in  32  store data.
- ex_mem_rd  in  5  destination register.
- ex_mem_RegWrite  in  1  register write enable.
- ex_mem_MemRead  in  1  load.
- ex_mem_MemWrite  in  1  store.
- ex_mem_ResultSrc  in  2  result select: 00 ALU, 01 memory, 10 link.
- ex_mem_link_val  in  32  PC+4.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address; always ex_mem_alu_result with bits [1:0] forced to 0.
- dmem_wdata  out  32  store data.
- dmem_ready  in  1  memory accepts/completes the access this cycle.
- dmem_rdata  in  32  read data; valid only in a cycle where dmem_ready=1.
- stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- mem_wb_rd  out  5  MEM/WB destination register.
- mem_wb_RegWrite  out  1  MEM/WB write enable.
- mem_wb_result  out  32  selected writeback value.
- mem_wb_exc  out  1  exception: misaligned access or bus timeout.
- wb_data  out  32  equals mem_wb_result; forwarding source for EX.

Behaviour:
- Request generation:
  - mem_op = MemRead | MemWrite.
  - misaligned = mem_op & (alu_result[1:0] != 0).
  - dmem_req = mem_op & ~misaligned & ~done, combinational.
  - dmem_we = MemWrite.
  - dmem_addr, dmem_wdata and dmem_we stay stable while dmem_req=1; this holds because the upstream stages are frozen.
- Handshake:
  - An access completes in any cycle where dmem_req=1 and dmem_ready=1. Zero-wait completion is legal.
  - dmem_ready while dmem_req=0 is ignored.
- stall_mem = dmem_req & ~dmem_ready & ~timeout_hit (combinational). Misaligned accesses never stall.
- FSM states:
  - IDLE:
    - dmem_req & ~dmem_ready -> WAIT; counter cleared to 1.
    - Otherwise stay in IDLE.
  - WAIT:
    - dmem_ready -> IDLE.
    - counter == TIMEOUT_CYCLES -> IDLE with timeout_hit=1 this cycle: no stall, access abandoned.
    - Otherwise counter increments.
  - done is unused; dmem_req drops by itself because EX/MEM advances after completion.
- MEM/WB register:
  - Updates every cycle.
  - While stall_mem=1: bubble (RegWrite=0, rd=0, result=0, exc=0).
  - Otherwise captures rd.
  - result comes from ResultSrc: 00 alu_result, 01 dmem_rdata, 10 link_val, 11 alu_result.
  - RegWrite is captured as ex_mem_RegWrite & ~misaligned & ~timeout_hit.
  - exc is captured as misaligned | timeout_hit.
- Latency: a non-memory op reaches MEM/WB after 1 cycle. A memory op reaches it 1 cycle after the ready cycle.
- Stores are blocked by misaligned or timeout: no write is issued, or the write is abandoned.
- Reset: on a clk edge with reset=1:
  - State goes to IDLE and the counter to 0.
  - All mem_wb_* outputs go to 0, so wb_data=0.
  - dmem_req and stall_mem follow their inputs combinationally; upstream reset makes them 0.
  - Reset during WAIT abandons the access; the memory must tolerate a dropped request.

Decomposition:
- Shared package:
  - ResultSrc encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_LINK=2'b10.
  - FSM state enum {ST_IDLE, ST_WAIT}.
  - TIMEOUT_CYCLES default.
- Optional sub-module mem_wb_reg: the MEM/WB pipeline register with bubble insertion. Everything else stays flat.

Test Plan:
- ALU op, ResultSrc=00, alu_result=0x0000_1234, RegWrite=1, rd=5 -> next cycle mem_wb_result=0x1234, RegWrite=1, rd=5; no dmem_req.
- Zero-wait load from addr 0x100 with dmem_ready=1, rdata=0xDEADBEEF -> stall_mem=0; next cycle mem_wb_result=0xDEADBEEF.
- Store to 0x200, wdata 0xCAFEF00D, ready after 3 cycles -> stall_mem=1 for 3 cycles; dmem_we=1 and addr/wdata stable; MEM/WB bubbles; then IDLE and RegWrite=0.
- Load at addr 0x102 -> no dmem_req, no stall; next cycle mem_wb_exc=1, RegWrite=0.
- Load with dmem_ready held 0 -> stall for exactly TIMEOUT_CYCLES (16) cycles; then exc=1, RegWrite=0, FSM in IDLE.
- JAL result (ResultSrc=10, link_val=0x0000_0044), then reset asserted mid-WAIT -> first: mem_wb_result=0x44; after the reset edge: all MEM/WB outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and helpers for the memory-access stage
package mem_stage_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_LINK = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Writeback value mux; the unused 2'b11 encoding falls back to the ALU result.
  function automatic logic [31:0] sel_result(input logic [1:0]  src,
                                             input logic [31:0] alu,
                                             input logic [31:0] rdata,
                                             input logic [31:0] link);
    case (src)
      RES_MEM:  sel_result = rdata;
      RES_LINK: sel_result = link;
      default:  sel_result = alu;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// rtl/mem_stage_mem_wb_reg.sv - MEM/WB pipeline register with bubble insertion
module mem_stage_mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic [31:0] result,
  input  logic        exc,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_RegWrite,
  output logic [31:0] mem_wb_result,
  output logic        mem_wb_exc
);

  // Capture every cycle; a stalled cycle loads an all-zero bubble so WB never sees a half-done access.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      mem_wb_rd       <= 5'd0;
      mem_wb_RegWrite <= 1'b0;
      mem_wb_result   <= 32'd0;
      mem_wb_exc      <= 1'b0;
    end else begin
      mem_wb_rd       <= rd;
      mem_wb_RegWrite <= reg_write;
      mem_wb_result   <= result;
      mem_wb_exc      <= exc;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with data-memory handshake and timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_store_val,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_RegWrite,
  input  logic        ex_mem_MemRead,
  input  logic        ex_mem_MemWrite,
  input  logic [1:0]  ex_mem_ResultSrc,
  input  logic [31:0] ex_mem_link_val,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_RegWrite,
  output logic [31:0] mem_wb_result,
  output logic        mem_wb_exc,
  output logic [31:0] wb_data
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             misaligned;
  logic             timeout_hit;

  // Request side: address/data come straight from the frozen EX/MEM register, so they stay stable.
  always_comb begin
    mem_op      = ex_mem_MemRead | ex_mem_MemWrite;
    misaligned  = mem_op & (ex_mem_alu_result[1:0] != 2'b00);
    dmem_req    = mem_op & ~misaligned;
    dmem_we     = ex_mem_MemWrite;
    dmem_addr   = {ex_mem_alu_result[31:2], 2'b00};
    dmem_wdata  = ex_mem_store_val;
    timeout_hit = (state == ST_WAIT) & dmem_req & ~dmem_ready & (cnt == TIMEOUT_CNT);
    stall_mem   = dmem_req & ~dmem_ready & ~timeout_hit;
  end

  // Wait tracking: count stalled cycles and give up on the access once the limit is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dmem_req && !dmem_ready) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          // A vanished request is treated like completion so the counter cannot run away.
          if (dmem_ready || !dmem_req || timeout_hit) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  mem_stage_mem_wb_reg u_mem_wb_reg (
    .clk             (clk),
    .reset           (reset),
    .bubble          (stall_mem),
    .rd              (ex_mem_rd),
    .reg_write       (ex_mem_RegWrite & ~misaligned & ~timeout_hit),
    .result          (sel_result(ex_mem_ResultSrc, ex_mem_alu_result, dmem_rdata, ex_mem_link_val)),
    .exc             (misaligned | timeout_hit),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_RegWrite (mem_wb_RegWrite),
    .mem_wb_result   (mem_wb_result),
    .mem_wb_exc      (mem_wb_exc)
  );

  assign wb_data = mem_wb_result;

endmodule
